// File: rtl/coax_rx_frame_ctrl.sv
// Drains a completed coax receive frame from the RX FIFO onto a valid/ready stream with first/last/error tags.
// Optional host-stall timeout enabled by defining COAX_RX_FRAME_CTRL_TIMEOUT_EN.
module coax_rx_frame_ctrl #(
    parameter int DEPTH          = 8,
    parameter int RECOVER_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [9:0]                 rx_data,
    input  logic                       rx_empty,
    input  logic                       rx_error,
    input  logic                       rx_active,
    output logic                       rx_read_strobe,
    output logic                       rx_reset,
    output logic [9:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_first,
    output logic                       out_last,
    output logic                       out_error,
    output logic [$clog2(DEPTH+1)-1:0] frame_words,
    output logic                       busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [RW-1:0] REC_LAST     = RW'(RECOVER_CYCLES - 1);
    localparam logic [9:0]    TIMEOUT_CODE = 10'h3FF;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_END, S_LOAD, S_PRESENT, S_POP, S_ERROR, S_CLEAR, S_RECOVER
    } state_t;

    state_t          r_state, w_state_next;
    logic [9:0]      r_out_data;
    logic            r_out_valid, r_out_first, r_out_last, r_out_error;
    logic            r_timeout;
    logic [CW-1:0]   r_count, r_frame_words;
    logic [RW-1:0]   r_rec;
    logic            w_hs, w_timeout;

    assign w_hs = r_out_valid && out_ready;

`ifdef COAX_RX_FRAME_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_stall;
    logic          w_stalled;

    assign w_stalled = (r_state == S_PRESENT) && r_out_valid && !out_ready;
    assign w_timeout = w_stalled && (r_stall == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall <= '0;
        else if (w_stalled && !w_timeout)
            r_stall <= r_stall + 1'b1;
        else
            r_stall <= '0;
    end
`else
    // Stall limit has no meaning without the timeout; tied off false.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        rx_read_strobe = 1'b0;
        rx_reset       = 1'b0;
        busy           = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (rx_error)       w_state_next = S_ERROR;
                else if (rx_active) w_state_next = S_WAIT_END;
                else if (!rx_empty) w_state_next = S_LOAD;
            end
            S_WAIT_END: begin
                if (rx_error)       w_state_next = S_ERROR;
                else if (!rx_active) w_state_next = rx_empty ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                rx_read_strobe = 1'b1;
                w_state_next   = S_POP;
            end
            S_POP:
                w_state_next = rx_error ? S_ERROR : S_PRESENT;
            S_PRESENT: begin
                if (w_hs)           w_state_next = rx_error ? S_ERROR : (r_out_last ? S_IDLE : S_LOAD);
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_ERROR:
                if (w_hs) w_state_next = S_CLEAR;
            S_CLEAR: begin
                rx_reset     = 1'b1;
                w_state_next = S_RECOVER;
            end
            S_RECOVER:
                if (r_rec == REC_LAST) w_state_next = S_IDLE;
            default:
                w_state_next = S_IDLE;
        endcase
    end

    // Each word is popped in LOAD before it is shown, so POP sees the post-pop
    // rx_empty and can tag the held word as last without any lookahead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_first   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_error   <= 1'b0;
            r_timeout     <= 1'b0;
            r_count       <= '0;
            r_frame_words <= '0;
            r_rec         <= '0;
        end else begin
            case (r_state)
                S_LOAD:
                    r_out_data <= rx_data;
                S_POP:
                    if (!rx_error) begin
                        r_out_valid <= 1'b1;
                        r_out_first <= (r_count == '0);
                        r_out_last  <= rx_empty;
                    end
                S_PRESENT: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        r_out_first <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_frame_words <= r_count + 1'b1;
                            r_count       <= '0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_out_valid <= 1'b0;
                        r_out_first <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_timeout   <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (!r_out_valid) begin
                        r_out_data  <= r_timeout ? TIMEOUT_CODE : rx_data;
                        r_out_valid <= 1'b1;
                        r_out_error <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_out_first <= 1'b0;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_error <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_count <= '0;
                    r_rec   <= '0;
                end
                S_RECOVER:
                    r_rec <= r_rec + 1'b1;
                default: ;
            endcase
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_first   = r_out_first;
    assign out_last    = r_out_last;
    assign out_error   = r_out_error;
    assign frame_words = r_frame_words;

endmodule

// File: tb/tb_coax_rx_frame_ctrl.sv
// Directed self-checking bench for coax_rx_frame_ctrl with a small behavioural receiver FIFO.
module tb_coax_rx_frame_ctrl;
    localparam logic [9:0] ERR_OVF = 10'h2E1;
    localparam logic [9:0] ERR_DUP = 10'h2C5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] rx_data;
    logic       rx_empty;
    logic       rx_error = 1'b0;
    logic       rx_active = 1'b0;
    logic       rx_read_strobe, rx_reset;
    logic [9:0] out_data;
    logic       out_valid, out_first, out_last, out_error, busy;
    logic       out_ready = 1'b0;
    logic [3:0] frame_words;

    always #5 clk = ~clk;

    coax_rx_frame_ctrl #(
        .DEPTH(8),
        .RECOVER_CYCLES(16),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_error(rx_error), .rx_active(rx_active),
        .rx_read_strobe(rx_read_strobe), .rx_reset(rx_reset),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .out_error(out_error),
        .frame_words(frame_words), .busy(busy)
    );

    // Receiver model: 8-deep FIFO, overflow raises rx_error, rx_reset clears everything.
    logic [9:0] q_mem [0:15];
    logic [4:0] q_cnt = '0;
    logic       push_en = 1'b0, err_req = 1'b0, flush_req = 1'b0;
    logic [9:0] push_v = '0, err_code = '0;

    always @(posedge clk) begin
        if (rx_reset || flush_req) begin
            q_cnt    <= '0;
            rx_error <= 1'b0;
        end else begin
            if (err_req) rx_error <= 1'b1;
            if (push_en) begin
                if (q_cnt == 5'd8) rx_error <= 1'b1;
                else begin
                    q_mem[q_cnt[3:0]] <= push_v;
                    q_cnt <= q_cnt + 5'd1;
                end
            end else if (rx_read_strobe && q_cnt != 5'd0) begin
                for (int i = 0; i < 15; i++) q_mem[4'(i)] <= q_mem[4'(i + 1)];
                q_cnt <= q_cnt - 5'd1;
            end
        end
    end

    assign rx_empty = (q_cnt == 5'd0);
    assign rx_data  = rx_error ? err_code : q_mem[0];

    // Stream / strobe monitor, sampled mid-cycle.
    int         hs_cnt = 0, strobe_cnt = 0, strobe_viol = 0, clr_cnt = 0;
    logic       prev_strobe = 1'b0;
    logic [9:0] log_data  [0:63];
    logic       log_first [0:63];
    logic       log_last  [0:63];
    logic       log_err   [0:63];

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            log_data[6'(hs_cnt)]  <= out_data;
            log_first[6'(hs_cnt)] <= out_first;
            log_last[6'(hs_cnt)]  <= out_last;
            log_err[6'(hs_cnt)]   <= out_error;
            hs_cnt <= hs_cnt + 1;
        end
        if (rx_read_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            if (rx_empty || prev_strobe) strobe_viol <= strobe_viol + 1;
        end
        prev_strobe <= rx_read_strobe;
        if (rx_reset) clr_cnt <= clr_cnt + 1;
    end

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int n, input logic [9:0] d0, input logic incr);
        rx_active = 1'b1;
        tick(1);
        for (int i = 0; i < n; i++) begin
            push_en = 1'b1;
            push_v  = incr ? d0 + 10'(i) : d0;
            tick(1);
        end
        push_en   = 1'b0;
        rx_active = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin tick(1); k++; end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_hs(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (hs_cnt < target && k < budget) begin tick(1); k++; end
        check(tag, 32'(hs_cnt), 32'(target));
    endtask

    task automatic wait_sig(input string tag, input int which, input int budget);
        int k;
        logic s;
        k = 0;
        s = (which == 0) ? out_valid : rx_reset;
        while (!s && k < budget) begin
            tick(1);
            k++;
            s = (which == 0) ? out_valid : rx_reset;
        end
        check(tag, 32'(s), 32'd1);
    endtask

    task automatic scan(input int base, input int n, input logic [9:0] d0, input logic incr,
                        output logic [31:0] fm, output logic [31:0] lm,
                        output logic [31:0] em, output int dok);
        fm = '0; lm = '0; em = '0; dok = 0;
        for (int i = 0; i < n; i++) begin
            fm = fm | (32'(log_first[6'(base + i)]) << i);
            lm = lm | (32'(log_last[6'(base + i)]) << i);
            em = em | (32'(log_err[6'(base + i)]) << i);
            if (log_data[6'(base + i)] === (incr ? d0 + 10'(i) : d0)) dok++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int base, sbase, cbase, good, n, dok;
        logic [31:0] fm, lm, em;

        // Reset state
        tick(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_words", 32'(frame_words), 32'd0);
        check("rst_strobe", 32'(rx_read_strobe), 32'd0);
        check("rst_rx_reset", 32'(rx_reset), 32'd0);
        reset_n = 1'b1;
        tick(1);

        // 8 words of 1B3, host always ready
        base = hs_cnt; sbase = strobe_cnt;
        out_ready = 1'b1;
        push_frame(8, 10'h1B3, 1'b0);
        wait_idle("t1_idle", 200);
        check("t1_words", 32'(hs_cnt - base), 32'd8);
        check("t1_strobes", 32'(strobe_cnt - sbase), 32'd8);
        scan(base, 8, 10'h1B3, 1'b0, fm, lm, em, dok);
        check("t1_data", 32'(dok), 32'd8);
        check("t1_first", fm, 32'h01);
        check("t1_last", lm, 32'h80);
        check("t1_err", em, 32'h00);
        check("t1_frame_words", 32'(frame_words), 32'd8);

        // Same frame, host stalls 20 cycles on word 3
        base = hs_cnt; sbase = strobe_cnt;
        push_frame(8, 10'h1B3, 1'b0);
        wait_hs("t2_two_words", base + 2, 100);
        out_ready = 1'b0;
        tick(2);
        good = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1 && out_data === 10'h1B3 && out_first === 1'b0) good++;
            tick(1);
        end
        check("t2_hold", 32'(good), 32'd20);
        check("t2_stall_pops", 32'(strobe_cnt - sbase), 32'd3);
        check("t2_stall_words", 32'(hs_cnt - base), 32'd2);
        out_ready = 1'b1;
        wait_idle("t2_idle", 200);
        check("t2_words", 32'(hs_cnt - base), 32'd8);
        check("t2_strobes", 32'(strobe_cnt - sbase), 32'd8);
        scan(base, 8, 10'h1B3, 1'b0, fm, lm, em, dok);
        check("t2_data", 32'(dok), 32'd8);
        check("t2_last", lm, 32'h80);

        // 9 words into an 8-deep receiver: overflow error word, clear, 16 recover cycles
        base = hs_cnt; sbase = strobe_cnt; cbase = clr_cnt;
        err_code = ERR_OVF;
        push_frame(9, 10'h0C0, 1'b1);
        wait_sig("t3_rx_reset", 1, 50);
        n = 0;
        do begin tick(1); n++; end while (busy && n < 100);
        // 16 RECOVER cycles; idle appears on the 17th edge after CLEAR
        check("t3_recover", 32'(n), 32'd17);
        check("t3_words", 32'(hs_cnt - base), 32'd1);
        check("t3_err_data", 32'(log_data[6'(base)]), 32'(ERR_OVF));
        check("t3_err_flags", {29'd0, log_first[6'(base)], log_last[6'(base)], log_err[6'(base)]}, 32'b011);
        check("t3_no_pops", 32'(strobe_cnt - sbase), 32'd0);
        check("t3_clears", 32'(clr_cnt - cbase), 32'd1);
        check("t3_frame_words", 32'(frame_words), 32'd8);

        // Receiver error while a frame is being drained
        base = hs_cnt; sbase = strobe_cnt; cbase = clr_cnt;
        err_code = ERR_DUP;
        push_frame(4, 10'h101, 1'b1);
        wait_hs("t4_two_words", base + 2, 100);
        err_req = 1'b1;
        tick(1);
        err_req = 1'b0;
        wait_sig("t4_rx_reset", 1, 50);
        wait_idle("t4_idle", 100);
        check("t4_words", 32'(hs_cnt - base), 32'd3);
        scan(base, 2, 10'h101, 1'b1, fm, lm, em, dok);
        check("t4_data", 32'(dok), 32'd2);
        check("t4_first_last", {fm[15:0], lm[15:0]}, {16'h0001, 16'h0000});
        check("t4_err_data", 32'(log_data[6'(base + 2)]), 32'(ERR_DUP));
        check("t4_err_flags", {30'd0, log_last[6'(base + 2)], log_err[6'(base + 2)]}, 32'b11);
        check("t4_pops", 32'(strobe_cnt - sbase), 32'd3);
        check("t4_clears", 32'(clr_cnt - cbase), 32'd1);
        check("t4_frame_words", 32'(frame_words), 32'd8);

        // Asynchronous reset in PRESENT
        cbase = clr_cnt;
        out_ready = 1'b0;
        push_frame(3, 10'h201, 1'b1);
        wait_sig("t5_valid", 0, 50);
        check("t5_present_data", 32'(out_data), 32'h201);
        check("t5_present_first", 32'(out_first), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_data", 32'(out_data), 32'd0);
        check("t5_async_first", 32'(out_first), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_frame_words", 32'(frame_words), 32'd0);
        flush_req = 1'b1;
        tick(2);
        flush_req = 1'b0;
        check("t5_no_rx_reset", 32'(clr_cnt - cbase), 32'd0);
        reset_n = 1'b1;
        tick(1);
        base = hs_cnt; sbase = strobe_cnt;
        out_ready = 1'b1;
        push_frame(3, 10'h301, 1'b1);
        wait_idle("t5_idle", 100);
        scan(base, 3, 10'h301, 1'b1, fm, lm, em, dok);
        check("t5_words", 32'(hs_cnt - base), 32'd3);
        check("t5_data", 32'(dok), 32'd3);
        check("t5_first_last", {fm[15:0], lm[15:0]}, {16'h0001, 16'h0004});
        check("t5_frame_words", 32'(frame_words), 32'd3);

        // Host stall: timeout build vs default build
        base = hs_cnt; sbase = strobe_cnt; cbase = clr_cnt;
        out_ready = 1'b0;
        push_frame(2, 10'h0A5, 1'b1);
        wait_sig("t6_valid", 0, 50);
`ifdef COAX_RX_FRAME_CTRL_TIMEOUT_EN
        n = 0;
        while (!(out_valid && out_error) && n < 100) begin tick(1); n++; end
        // 32 stall cycles, one dropped-valid cycle, then the error word
        check("t6_timeout_cycles", 32'(n), 32'd33);
        check("t6_timeout_data", 32'(out_data), 32'h3FF);
        check("t6_timeout_last", 32'(out_last), 32'd1);
        out_ready = 1'b1;
        wait_sig("t6_rx_reset", 1, 20);
        wait_idle("t6_idle", 100);
        check("t6_clears", 32'(clr_cnt - cbase), 32'd1);
        check("t6_words", 32'(hs_cnt - base), 32'd1);
`else
        tick(2000);
        check("t6_still_valid", 32'(out_valid), 32'd1);
        check("t6_still_data", 32'(out_data), 32'h0A5);
        check("t6_still_busy", 32'(busy), 32'd1);
        check("t6_no_clear", 32'(clr_cnt - cbase), 32'd0);
        check("t6_one_pop", 32'(strobe_cnt - sbase), 32'd1);
        out_ready = 1'b1;
        wait_idle("t6_idle", 100);
        check("t6_words", 32'(hs_cnt - base), 32'd2);
        check("t6_frame_words", 32'(frame_words), 32'd2);
`endif

        check("strobe_rules", 32'(strobe_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
